// File: rtl/stack_alu_pkg.sv
// Shared definitions for the stack ALU command sequencer: opcode encodings,
// FSM state type and the pre-issue legality check.
package stack_alu_pkg;

   localparam logic [2:0] OP_NOP  = 3'b000;
   localparam logic [2:0] OP_ADD  = 3'b100;
   localparam logic [2:0] OP_MUL  = 3'b101;
   localparam logic [2:0] OP_PUSH = 3'b110;
   localparam logic [2:0] OP_POP  = 3'b111;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_SETTLE,
      S_CAPTURE,
      S_RESP,
      S_DRAIN_ISSUE,
      S_DRAIN_SETTLE
   } seq_state_t;

   // Any opcode with bit 2 clear is a NOP and always legal.
   function automatic logic op_legal(input logic [2:0] op, input int unsigned depth,
                                     input int unsigned cap);
      logic ok;
      ok = 1'b1;
      if (op[2]) begin
         case (op)
            OP_ADD, OP_MUL: ok = (depth >= 2);
            OP_PUSH:        ok = (depth < cap);
            default:        ok = (depth >= 1);
         endcase
      end
      return ok;
   endfunction

endpackage

// File: rtl/stack_alu_depth_ctr.sv
// Shadow occupancy counter for the attached ALU stack.
module stack_alu_depth_ctr #(
   parameter int DEPTH = 8,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          inc_i,
   input  logic          dec_i,
   input  logic          clr_i,
   output logic [CW-1:0] count_o,
   output logic          full_o,
   output logic          empty_o,
   output logic          ge2_o
);

   logic [CW-1:0] cnt_q, cnt_d;

   // next count: clear wins, simultaneous inc/dec cancel
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)                cnt_d = '0;
      else if (inc_i && !dec_i) cnt_d = cnt_q + CW'(1);
      else if (dec_i && !inc_i) cnt_d = cnt_q - CW'(1);
   end

   // count register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign count_o = cnt_q;
   assign full_o  = (cnt_q == CW'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign ge2_o   = (cnt_q >= CW'(2));

endmodule

// File: rtl/stack_alu_sequencer.sv
// Command sequencer in front of stack_based_alu. Checks legality against a
// shadow depth count, strobes legal instructions with an issue/settle/capture
// cadence, and returns results over a valid/ready response channel.
// Optional: STACK_ALU_SEQ_ERRCNT_EN adds an 8-bit saturating err_count output.
//
// state          | meaning
// S_IDLE         | ready for a command or flush
// S_ISSUE        | opcode and operand driven to the ALU
// S_SETTLE       | opcode back to NOP, operand held
// S_CAPTURE      | ALU result registered, depth updated
// S_RESP         | response held until rsp_ready
// S_DRAIN_ISSUE  | flush: POP strobe
// S_DRAIN_SETTLE | flush: NOP gap, depth decremented
module stack_alu_sequencer
   import stack_alu_pkg::*;
#(
   parameter  int WIDTH = 8,
   parameter  int DEPTH = 8,
   localparam int DW    = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [2:0]       cmd_opcode,
   input  logic [WIDTH-1:0] cmd_data,
   input  logic             flush,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_data,
   output logic             rsp_ovf,
   output logic             rsp_err,
   output logic [DW-1:0]    depth,
   output logic [2:0]       alu_opcode,
   output logic [WIDTH-1:0] alu_input_data,
   input  logic [WIDTH-1:0] alu_output_data,
   input  logic             alu_overflow
`ifdef STACK_ALU_SEQ_ERRCNT_EN
   ,
   output logic [7:0]       err_count
`endif
);

   seq_state_t       state_q, state_d;
   logic [2:0]       op_q, op_d;
   logic [WIDTH-1:0] din_q, din_d;
   logic [WIDTH-1:0] rdata_q, rdata_d;
   logic             rovf_q, rovf_d;
   logic             rerr_q, rerr_d;
   logic             legal;
   logic             ctr_inc, ctr_dec;
   logic             full, empty, ge2;
   logic [DW-1:0]    depth_w;

   stack_alu_depth_ctr #(.DEPTH(DEPTH), .CW(DW)) u_depth (
      .clk     (clk),
      .rst_n   (rst_n),
      .inc_i   (ctr_inc),
      .dec_i   (ctr_dec),
      .clr_i   (1'b0),
      .count_o (depth_w),
      .full_o  (full),
      .empty_o (empty),
      .ge2_o   (ge2)
   );

   assign legal          = op_legal(cmd_opcode, 32'(depth_w), DEPTH);
   assign cmd_ready      = rst_n && (state_q == S_IDLE) && !flush;
   assign rsp_valid      = (state_q == S_RESP);
   assign rsp_data       = rdata_q;
   assign rsp_ovf        = rovf_q;
   assign rsp_err        = rerr_q;
   assign depth          = depth_w;
   assign alu_input_data = din_q;

   // next state, ALU strobes, response capture and depth updates
   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      din_d      = din_q;
      rdata_d    = rdata_q;
      rovf_d     = rovf_q;
      rerr_d     = rerr_q;
      ctr_inc    = 1'b0;
      ctr_dec    = 1'b0;
      alu_opcode = OP_NOP;
      unique case (state_q)
         S_IDLE: begin
            if (flush) begin
               if (empty) begin
                  state_d = S_RESP;
                  rdata_d = '0;
                  rovf_d  = 1'b0;
                  rerr_d  = 1'b0;
               end else begin
                  state_d = S_DRAIN_ISSUE;
               end
            end else if (cmd_valid) begin
               rdata_d = '0;
               rovf_d  = 1'b0;
               rerr_d  = !legal;
               if (!cmd_opcode[2] || !legal) begin
                  state_d = S_RESP;
               end else begin
                  state_d = S_ISSUE;
                  op_d    = cmd_opcode;
                  din_d   = cmd_data;
               end
            end
         end
         S_ISSUE: begin
            alu_opcode = op_q;
            state_d    = S_SETTLE;
         end
         S_SETTLE: state_d = S_CAPTURE;
         S_CAPTURE: begin
            rdata_d = alu_output_data;
            // the ALU overflow flag is stale for PUSH/POP
            rovf_d  = alu_overflow && (op_q[2:1] == 2'b10);
            rerr_d  = 1'b0;
            if (op_q == OP_PUSH) ctr_inc = !full;
            else                 ctr_dec = 1'b1;
            state_d = S_RESP;
         end
         S_RESP: begin
            if (rsp_ready) state_d = S_IDLE;
         end
         S_DRAIN_ISSUE: begin
            alu_opcode = OP_POP;
            state_d    = S_DRAIN_SETTLE;
         end
         S_DRAIN_SETTLE: begin
            ctr_dec = 1'b1;
            if (!ge2) begin
               state_d = S_RESP;
               rdata_d = '0;
               rovf_d  = 1'b0;
               rerr_d  = 1'b0;
            end else begin
               state_d = S_DRAIN_ISSUE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // state and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         op_q    <= OP_NOP;
         din_q   <= '0;
         rdata_q <= '0;
         rovf_q  <= 1'b0;
         rerr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         din_q   <= din_d;
         rdata_q <= rdata_d;
         rovf_q  <= rovf_d;
         rerr_q  <= rerr_d;
      end
   end

`ifdef STACK_ALU_SEQ_ERRCNT_EN
   logic [7:0] errcnt_q, errcnt_d;
   logic       flush_clr;

   assign flush_clr = ((state_q == S_IDLE) && flush && empty) ||
                      ((state_q == S_DRAIN_SETTLE) && !ge2);

   // completed flush clears; rejected-response handshakes count up, saturating
   always_comb begin
      errcnt_d = errcnt_q;
      if (flush_clr)
         errcnt_d = '0;
      else if (rsp_valid && rsp_ready && rerr_q && (errcnt_q != 8'hFF))
         errcnt_d = errcnt_q + 8'd1;
   end

   // error counter register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) errcnt_q <= '0;
      else        errcnt_q <= errcnt_d;
   end

   assign err_count = errcnt_q;
`endif

endmodule
